// File: rtl/uart_fb_pkg.sv
// Shared types and byte codes for the UART framebuffer loader.
// The state enum, the sync byte and the packet command codes live here.
package uart_fb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_SEL,
    ST_ADR2,
    ST_ADR1,
    ST_ADR0,
    ST_CNT1,
    ST_CNT0,
    ST_PIXH,
    ST_PIXL,
    ST_CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_SEL   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CHR_A     = 8'h41;
  localparam logic [7:0] CHR_F     = 8'h46;

  // Case-insensitive match of a byte against an upper-case ASCII letter.
  function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
    return (b == upper) || (b == (upper | 8'h20));
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte watchdog: loadable down-counter that flags the last idle cycle.
// Held at zero while the parser is idle so it can never fire there.
module uart_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic rst,
  input  logic load,
  input  logic hold,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (rst || hold) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= CW'(TIMEOUT_CYCLES);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Depends only on the register, so the FSM may use it without a comb loop.
  assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/uart_fb_loader.sv
// Parses sync/command packets from the UART byte stream, streams pixels to the
// framebuffer write port, and drives the VGA display-buffer select.
module uart_fb_loader
  import uart_fb_pkg::*;
#(
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_wdata,
  output logic              image_sel,
  output logic              busy,
  output logic              err,
  output logic              pkt_ok
);
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [15:0]       cnt_shift;
  logic [7:0]        csum_reg, csum_next;
  logic [3:0]        red_reg, red_next;
  logic [11:0]       fb_wdata_reg, fb_wdata_next;
  logic              fb_we_reg, fb_we_next;
  logic              image_sel_reg, image_sel_next;
  logic              err_reg, err_next;
  logic              pkt_ok_reg, pkt_ok_next;
  logic              tmo_expire, tmo_hold;

  assign cnt_shift = {cnt_reg[7:0], rx_data};
  assign tmo_hold  = (state_next == ST_IDLE);

  uart_rx_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK   (CLK),
    .rst   (rst),
    .load  (rx_valid),
    .hold  (tmo_hold),
    .expire(tmo_expire)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      fb_addr_reg   <= '0;
      cnt_reg       <= '0;
      csum_reg      <= '0;
      red_reg       <= '0;
      fb_wdata_reg  <= '0;
      fb_we_reg     <= 1'b0;
      image_sel_reg <= 1'b0;
      err_reg       <= 1'b0;
      pkt_ok_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      fb_addr_reg   <= fb_addr_next;
      cnt_reg       <= cnt_next;
      csum_reg      <= csum_next;
      red_reg       <= red_next;
      fb_wdata_reg  <= fb_wdata_next;
      fb_we_reg     <= fb_we_next;
      image_sel_reg <= image_sel_next;
      err_reg       <= err_next;
      pkt_ok_reg    <= pkt_ok_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    fb_addr_next   = fb_addr_reg;
    cnt_next       = cnt_reg;
    csum_next      = csum_reg;
    red_next       = red_reg;
    fb_wdata_next  = fb_wdata_reg;
    fb_we_next     = 1'b0;
    image_sel_next = image_sel_reg;
    err_next       = err_reg;
    pkt_ok_next    = 1'b0;

    if (rx_valid) begin
      // Every packet byte between the sync and the checksum feeds the XOR.
      if (state_reg != ST_IDLE && state_reg != ST_CSUM) begin
        csum_next = csum_reg ^ rx_data;
      end
      case (state_reg)
        ST_IDLE: begin
          if (is_letter(rx_data, CHR_A)) begin
            image_sel_next = 1'b0;
          end else if (is_letter(rx_data, CHR_F)) begin
            image_sel_next = 1'b1;
          end else if (rx_data == SYNC_BYTE) begin
            csum_next  = '0;
            state_next = ST_CMD;
          end
        end
        ST_CMD: begin
          case (rx_data)
            CMD_WRITE: state_next = ST_ADR2;
            CMD_SEL:   state_next = ST_SEL;
            CMD_CLEAR: begin
              err_next   = 1'b0;
              state_next = ST_IDLE;
            end
            default: begin
              err_next   = 1'b1;
              state_next = ST_IDLE;
            end
          endcase
        end
        ST_SEL: begin
          image_sel_next = rx_data[0];
          state_next     = ST_CSUM;
        end
        // Shifting in big-endian bytes and truncating keeps the low ADDR_W bits.
        ST_ADR2: begin
          addr_next  = ADDR_W'(rx_data);
          state_next = ST_ADR1;
        end
        ST_ADR1: begin
          addr_next  = ADDR_W'({addr_reg, rx_data});
          state_next = ST_ADR0;
        end
        ST_ADR0: begin
          addr_next  = ADDR_W'({addr_reg, rx_data});
          state_next = ST_CNT1;
        end
        ST_CNT1: begin
          cnt_next   = cnt_shift;
          state_next = ST_CNT0;
        end
        ST_CNT0: begin
          cnt_next   = cnt_shift;
          state_next = (cnt_shift == 16'd0) ? ST_CSUM : ST_PIXH;
        end
        ST_PIXH: begin
          red_next   = rx_data[3:0];
          state_next = ST_PIXL;
        end
        ST_PIXL: begin
          fb_we_next    = 1'b1;
          fb_addr_next  = addr_reg;
          fb_wdata_next = {red_reg, rx_data};
          addr_next     = addr_reg + ADDR_W'(1);
          cnt_next      = cnt_reg - 16'd1;
          state_next    = (cnt_reg == 16'd1) ? ST_CSUM : ST_PIXH;
        end
        ST_CSUM: begin
          if (rx_data == csum_reg) begin
            pkt_ok_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (tmo_expire && state_reg != ST_IDLE) begin
      err_next   = 1'b1;
      state_next = ST_IDLE;
    end
  end

  assign fb_we     = fb_we_reg;
  assign fb_addr   = fb_addr_reg;
  assign fb_wdata  = fb_wdata_reg;
  assign image_sel = image_sel_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign err       = err_reg;
  assign pkt_ok    = pkt_ok_reg;

endmodule

// File: tb/tb_uart_fb_loader.sv
// Self-checking bench for uart_fb_loader: packets are built from field values,
// expected writes and checksums come from a queue-based packet model.
module tb_uart_fb_loader;
  localparam int ADDR_W = 17;
  localparam int TMO    = 100;

  logic              CLK = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_wdata;
  logic              image_sel;
  logic              busy;
  logic              err;
  logic              pkt_ok;

  int errors = 0;
  int checks = 0;

  logic [28:0] wr_q[$];
  logic [28:0] exp_q[$];
  logic [11:0] pix_q[$];
  logic [7:0]  byte_q[$];
  int          pkt_cnt = 0;
  int          exp_pkt = 0;
  logic        exp_err = 1'b0;
  logic        exp_sel = 1'b0;

  uart_fb_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .image_sel(image_sel),
    .busy     (busy),
    .err      (err),
    .pkt_ok   (pkt_ok)
  );

  always #5 CLK = ~CLK;

  // Record every framebuffer write and every cycle pkt_ok is high.
  always @(negedge CLK) begin
    if (fb_we) wr_q.push_back({fb_addr, fb_wdata});
    if (pkt_ok) pkt_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; presents one byte for one cycle, then junk with rx_valid low.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (g) @(negedge CLK);
  endtask

  // Builds a write packet from start address and pix_q, appends expected writes.
  task automatic send_write_pkt(input logic [23:0] start, input bit use_fixed,
                                input logic [7:0] csum_val, input int gap_max,
                                input bit rand_hi);
    logic [7:0] cs;
    logic [7:0] sent;
    logic [3:0] hi;
    int         n;
    int         a;
    n = pix_q.size();
    byte_q.delete();
    byte_q.push_back(8'h57);
    byte_q.push_back(start[23:16]);
    byte_q.push_back(start[15:8]);
    byte_q.push_back(start[7:0]);
    byte_q.push_back(8'(n >> 8));
    byte_q.push_back(8'(n));
    foreach (pix_q[i]) begin
      hi = rand_hi ? 4'($urandom) : 4'h0;
      byte_q.push_back({hi, pix_q[i][11:8]});
      byte_q.push_back(pix_q[i][7:0]);
      a = (int'(start) + i) % (1 << ADDR_W);
      exp_q.push_back({ADDR_W'(a), pix_q[i]});
    end
    cs = 8'h00;
    foreach (byte_q[i]) cs = cs ^ byte_q[i];
    sent = use_fixed ? csum_val : cs;
    send_byte(8'hA5, gap_max);
    foreach (byte_q[i]) send_byte(byte_q[i], gap_max);
    send_byte(sent, gap_max);
    if (sent == cs) exp_pkt++;
    else exp_err = 1'b1;
    $display("pkt write start=%06h count=%0d csum_sent=%02h csum_model=%02h", start, n, sent, cs);
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h46;
    idle(1);
    rx_valid = 1'b0;
    idle(1);
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got=%b want=0", fb_we); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL reset_fb_addr got=%h want=0", fb_addr); end
    checks++; if (fb_wdata !== '0) begin errors++; $display("FAIL reset_fb_wdata got=%h want=0", fb_wdata); end
    checks++; if (image_sel !== 1'b0) begin errors++; $display("FAIL reset_image_sel got=%b want=0", image_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (pkt_ok !== 1'b0) begin errors++; $display("FAIL reset_pkt_ok got=%b want=0", pkt_ok); end
    rst = 1'b0;
    idle(1);
    $display("reset done");
  endtask

  task automatic test_write_basic();
    wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
    pix_q.push_back(12'hFFF);
    pix_q.push_back(12'h123);
    send_write_pkt(24'h000010, 1'b0, 8'h00, 0, 1'b0);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_wr_count got=%0d want=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_wr[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL basic_pkt_ok got=%0d want=%0d", pkt_cnt, exp_pkt); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL basic_err got=%b want=%b", err, exp_err); end
  endtask

  task automatic test_bad_csum();
    wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
    pix_q.push_back(12'hFFF);
    pix_q.push_back(12'h123);
    send_write_pkt(24'h000010, 1'b1, 8'h00, 1, 1'b0);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("FAIL badcs_wr_count got=%0d want=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL badcs_wr[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL badcs_pkt_ok got=%0d want=%0d", pkt_cnt, exp_pkt); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL badcs_err got=%b want=%b", err, exp_err); end
    send_byte(8'hA5, 0);
    send_byte(8'h43, 0);
    exp_err = 1'b0;
    idle(1);
    $display("cmd clear-error");
    checks++; if (err !== exp_err) begin errors++; $display("FAIL clear_err got=%b want=%b", err, exp_err); end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'hA5, 0);
    send_byte(8'h99, 0);
    exp_err = 1'b1;
    idle(1);
    $display("cmd unknown 0x99");
    checks++; if (err !== exp_err) begin errors++; $display("FAIL badcmd_err got=%b want=%b", err, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy got=%b want=0", busy); end
    send_byte(8'hA5, 0);
    send_byte(8'h43, 0);
    exp_err = 1'b0;
    idle(1);
    checks++; if (err !== exp_err) begin errors++; $display("FAIL badcmd_clear got=%b want=%b", err, exp_err); end
  endtask

  task automatic test_wrap();
    wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
    pix_q.push_back(12'($urandom));
    pix_q.push_back(12'($urandom));
    send_write_pkt(24'h01FFFF, 1'b0, 8'h00, 1, 1'b1);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_wr_count got=%0d want=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_wr[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL wrap_pkt_ok got=%0d want=%0d", pkt_cnt, exp_pkt); end
  endtask

  task automatic test_image_sel();
    logic [7:0] cs;
    send_byte(8'h46, 0);
    exp_sel = 1'b1;
    $display("cmd F");
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL sel_F got=%b want=%b", image_sel, exp_sel); end
    send_byte(8'h61, 0);
    exp_sel = 1'b0;
    $display("cmd a");
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL sel_a got=%b want=%b", image_sel, exp_sel); end
    pkt_cnt = 0;
    cs = 8'h53 ^ 8'h01;
    send_byte(8'hA5, 0);
    send_byte(8'h53, 0);
    send_byte(8'h01, 0);
    send_byte(cs, 0);
    exp_sel = 1'b1;
    idle(2);
    $display("pkt select value=1 csum=%02h", cs);
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL sel_pkt got=%b want=%b", image_sel, exp_sel); end
    checks++; if (pkt_cnt != 1) begin errors++; $display("FAIL sel_pkt_ok got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_timeout();
    send_byte(8'h61, 0);
    exp_sel = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    $display("pkt stalled after 3 bytes");
    idle(TMO - 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_early_busy got=%b want=1", busy); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL tmo_early_err got=%b want=%b", err, exp_err); end
    idle(20);
    exp_err = 1'b1;
    checks++; if (err !== exp_err) begin errors++; $display("FAIL tmo_err got=%b want=%b", err, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got=%b want=0", busy); end
    send_byte(8'h46, 0);
    exp_sel = 1'b1;
    $display("cmd F after timeout");
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL tmo_sel got=%b want=%b", image_sel, exp_sel); end
    send_byte(8'hA5, 0);
    send_byte(8'h43, 0);
    exp_err = 1'b0;
    idle(1);
    checks++; if (err !== exp_err) begin errors++; $display("FAIL tmo_clear got=%b want=%b", err, exp_err); end
  endtask

  task automatic test_reset_mid();
    wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
    send_byte(8'hA5, 0); send_byte(8'h57, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h0F, 0);
    rst = 1'b1;
    idle(2);
    $display("reset between PIXH and PIXL");
    checks++;
    if ({fb_we, fb_addr, fb_wdata, image_sel, busy, err, pkt_ok} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got we=%b addr=%h data=%h sel=%b busy=%b err=%b ok=%b want all 0",
               fb_we, fb_addr, fb_wdata, image_sel, busy, err, pkt_ok);
    end
    rst = 1'b0;
    exp_sel = 1'b0;
    exp_err = 1'b0;
    send_byte(8'h46, 0);
    exp_sel = 1'b1;
    idle(2);
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL midrst_idle_parse got=%b want=%b", image_sel, exp_sel); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL midrst_no_write got=%0d want=0", wr_q.size()); end
    pix_q.push_back(12'h5A5);
    send_write_pkt(24'h000020, 1'b0, 8'h00, 1, 1'b1);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_wr_count got=%0d want=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_wr[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL midrst_pkt_ok got=%0d want=%0d", pkt_cnt, exp_pkt); end
  endtask

  task automatic test_back_to_back();
    wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
    // PIXL bytes 0x46 ('F') and 0x61 ('a') must be treated as pixel data.
    pix_q.push_back(12'h146);
    pix_q.push_back(12'hA61);
    send_write_pkt(24'($urandom), 1'b0, 8'h00, 0, 1'b1);
    pix_q.delete();
    pix_q.push_back(12'($urandom));
    pix_q.push_back(12'($urandom));
    send_write_pkt(24'($urandom), 1'b0, 8'h00, 0, 1'b1);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_wr_count got=%0d want=%0d", wr_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_wr[%0d] got=%h want=%h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL b2b_pkt_ok got=%0d want=%0d", pkt_cnt, exp_pkt); end
    checks++; if (image_sel !== exp_sel) begin errors++; $display("FAIL b2b_sel got=%b want=%b", image_sel, exp_sel); end
  endtask

  task automatic test_random();
    int n;
    bit bad;
    for (int k = 0; k < 8; k++) begin
      wr_q.delete(); exp_q.delete(); pix_q.delete(); pkt_cnt = 0; exp_pkt = 0;
      n = int'($urandom_range(4, 0));
      for (int p = 0; p < n; p++) pix_q.push_back(12'($urandom));
      bad = ($urandom_range(3, 0) == 0);
      send_write_pkt(24'($urandom), bad, 8'($urandom), 2, 1'b1);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_wr_count got=%0d want=%0d", k, wr_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_wr[%0d] got=%h want=%h", k, i, wr_q[i], exp_q[i]);
        end
      end
      checks++; if (pkt_cnt != exp_pkt) begin errors++; $display("FAIL rand%0d_pkt_ok got=%0d want=%0d", k, pkt_cnt, exp_pkt); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rand%0d_err got=%b want=%b", k, err, exp_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy got=%b want=0", k, busy); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge CLK);
    test_reset();
    test_write_basic();
    test_bad_csum();
    test_bad_cmd();
    test_wrap();
    test_image_sel();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
